mult_div_unit: RTL and testbench

Execute-stage multiply/divide unit that sits directly downstream of the ID/EX pipeline register. It takes that register's multiply/divide controls and operands, and owns the architectural HI/LO registers. It runs MULT/MULTU/DIV/DIVU as fixed-latency background operations and services MTHI/MTLO writes. It exposes busy and stall status to the hazard unit so MFHI/MFLO and back-to-back mult/div instructions wait for the result.

---
 rtl/mult_div_unit_pkg.sv | 31 +++
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
//   Shared definitions for the execute-stage multiply/divide unit:
//   operation encodings, default latencies and HI/LO write-select encodings.
// ---------------------------------------------------------------------------
package mdu_pkg;

    // Operation select as it leaves the ID/EX register (MultDivOp_out).
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    // Default cycles from accept to HI/LO commit.
    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    // MTHI/MTLO target select (HiLo_out).
    localparam logic HILO_SEL_HI = 1'b1;
    localparam logic HILO_SEL_LO = 1'b0;

    // Countdown width able to hold the larger of the two latencies.
    function automatic int mdu_cnt_width(input int mult_lat, input int div_lat);
        int max_lat;
        max_lat = (mult_lat > div_lat) ? mult_lat : div_lat;
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Execute-stage multiply/divide unit. Owns the architectural HI/LO
//   registers, runs MULT/MULTU/DIV/DIVU as fixed-latency background
//   operations and services MTHI/MTLO writes.
//
//   Ports
//     clk       in   clock, all state on rising edge
//     rst       in   asynchronous active-low reset
//     start     in   start an operation
//     op        in   [1:0] MULT/MULTU/DIV/DIVU
//     a, b      in   [31:0] rs / rt operands
//     hilo_we   in   MTHI/MTLO write enable
//     hilo_sel  in   1 = HI, 0 = LO
//     cancel    in   exception flush, aborts in-flight op
//     busy      out  operation in flight
//     stall     out  busy | start (combinational)
//     hi, lo    out  [31:0] HI/LO registers
//
//   Handshake: start is a request with no ready; it is accepted on an edge
//   where the unit is idle and cancel is low. The hazard unit must hold
//   upstream while stall is high, so a start arriving while busy is a
//   protocol error and is dropped without disturbing the in-flight op.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic        cancel,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = mdu_cnt_width(MULT_LAT, DIV_LAT);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] r_count;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_pend_hi;
    logic [31:0]   r_pend_lo;

    logic               w_idle;
    logic               w_accept;
    logic               w_commit;
    logic               w_hilo_wr;
    logic               w_signed;
    logic               w_is_div;
    logic               w_b_zero;
    logic               w_ovf;
    logic signed [63:0] w_ma;
    logic signed [63:0] w_mb;
    logic signed [63:0] w_prod;
    logic signed [32:0] w_da;
    logic signed [32:0] w_db;
    logic signed [32:0] w_db_safe;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign w_idle   = (r_count == '0);
    assign w_accept = w_idle & start & ~cancel;
    // Cancel on the final edge suppresses the commit.
    assign w_commit = (r_count == CNT_ONE) & ~cancel;
    // A start in the same cycle takes priority over an MTHI/MTLO write.
    assign w_hilo_wr = w_idle & hilo_we & ~start;

    assign w_signed = (op == MDU_MULT) | (op == MDU_DIV);
    assign w_is_div = op[1];
    assign w_b_zero = (b == 32'h0);
    assign w_ovf    = w_signed & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);

    // 64-bit operands: the low 64 bits of a 64x64 product are the exact
    // signed or unsigned 32x32 product depending on the extension.
    assign w_ma   = {{32{w_signed & a[31]}}, a};
    assign w_mb   = {{32{w_signed & b[31]}}, b};
    assign w_prod = w_ma * w_mb;

    // 33-bit operands make one signed divider serve both DIV and DIVU.
    // The divisor is forced non-zero so simulation never sees X; the
    // divide-by-zero result is selected separately below.
    assign w_da      = {w_signed & a[31], a};
    assign w_db      = {w_signed & b[31], b};
    assign w_db_safe = w_b_zero ? 33'sd1 : w_db;
    assign w_quo     = 32'(w_da / w_db_safe);
    assign w_rem     = 32'(w_da % w_db_safe);

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (w_is_div) begin
            if (w_b_zero) begin
                w_res_hi = a;
                w_res_lo = 32'hFFFF_FFFF;
            end else if (w_ovf) begin
                w_res_hi = 32'h0;
                w_res_lo = 32'h8000_0000;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_hi      <= 32'h0;
            r_lo      <= 32'h0;
            r_pend_hi <= 32'h0;
            r_pend_lo <= 32'h0;
        end else begin
            if (cancel) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count   <= w_is_div ? DIV_CNT : MULT_CNT;
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
            end else if (!w_idle) begin
                r_count <= r_count - CNT_ONE;
            end

            // Commit needs busy, MTHI/MTLO needs idle: never both.
            if (w_commit) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else if (w_hilo_wr) begin
                if (hilo_sel == HILO_SEL_HI) begin
                    r_hi <= a;
                end else begin
                    r_lo <= a;
                end
            end
        end
    end

    assign busy  = ~w_idle;
    assign stall = ~w_idle | start;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed bench for mult_div_unit with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hilo_we;
    logic        hilo_sel;
    logic        cancel;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    mult_div_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .cancel   (cancel),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge; returns sampled 1ns after that edge.
    task automatic drive_start(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        step();
        start = 1'b0;
    endtask

    task automatic drive_hilo(input logic sel, input logic [31:0] va);
        hilo_we  = 1'b1;
        hilo_sel = sel;
        a        = va;
        step();
        hilo_we  = 1'b0;
    endtask

    // Counts samples with busy high; bounded so a stuck busy terminates.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        start = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_start got=%b exp=1", stall); end
        start = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall_idle got=%b exp=0", stall); end
        #3 rst = 1'b1;
        step();
    endtask

    task automatic test_mult();
        int n;
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFE; b = 32'd3;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mult_stall_start got=%b exp=1", stall); end
        step();
        start = 1'b0;
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL mult_no_partial got=%h exp=%h", hi, 32'h0); end
        wait_idle(n);
        total++; if (n !== 5) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=%h", hi, 32'hFFFF_FFFF); end
        total++; if (lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h exp=%h", lo, 32'hFFFF_FFFA); end

        drive_start(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        total++; if ({hi, lo} !== 64'h0000_0000_0000_0001) begin bad++; $display("FAIL mult_neg1sq got=%h exp=%h", {hi, lo}, 64'h1); end
    endtask

    task automatic test_multu();
        int n;
        drive_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        total++; if (n !== 5) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
        total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=%h", hi, 32'hFFFF_FFFE); end
        total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=%h", lo, 32'h1); end
    endtask

    task automatic test_div();
        int n;
        drive_start(2'b10, 32'hFFFF_FFF9, 32'd2);   // -7 / 2
        wait_idle(n);
        total++; if (n !== 10) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=%h", lo, 32'hFFFF_FFFD); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=%h", hi, 32'hFFFF_FFFF); end

        drive_start(2'b10, 32'd7, 32'hFFFF_FFFE);   // 7 / -2
        wait_idle(n);
        total++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_negdivisor got=%h exp=%h", {hi, lo}, {32'd1, 32'hFFFF_FFFD}); end

        drive_start(2'b11, 32'hFFFF_FFFF, 32'd2);   // unsigned
        wait_idle(n);
        total++; if ({hi, lo} !== {32'd1, 32'h7FFF_FFFF}) begin bad++; $display("FAIL divu_big got=%h exp=%h", {hi, lo}, {32'd1, 32'h7FFF_FFFF}); end

        drive_start(2'b11, 32'd7, 32'd0);
        wait_idle(n);
        total++; if ({hi, lo} !== {32'd7, 32'hFFFF_FFFF}) begin bad++; $display("FAIL divu_zero got=%h exp=%h", {hi, lo}, {32'd7, 32'hFFFF_FFFF}); end

        drive_start(2'b10, 32'hFFFF_FFFB, 32'd0);   // -5 / 0
        wait_idle(n);
        total++; if ({hi, lo} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin bad++; $display("FAIL div_zero got=%h exp=%h", {hi, lo}, {32'hFFFF_FFFB, 32'hFFFF_FFFF}); end

        drive_start(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        total++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin bad++; $display("FAIL div_ovf got=%h exp=%h", {hi, lo}, {32'h0, 32'h8000_0000}); end
    endtask

    task automatic test_hilo();
        int n;
        // lo holds 0x80000000 from the previous test.
        drive_hilo(1'b1, 32'h1234_5678);
        total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi got=%h exp=%h", hi, 32'h1234_5678); end
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL mthi_lo_hold got=%h exp=%h", lo, 32'h8000_0000); end

        drive_hilo(1'b0, 32'hCAFE_0001);
        total++; if (lo !== 32'hCAFE_0001) begin bad++; $display("FAIL mtlo got=%h exp=%h", lo, 32'hCAFE_0001); end

        // MTLO while a DIV is in flight is dropped.
        drive_start(2'b10, 32'd100, 32'd7);
        drive_hilo(1'b0, 32'hDEAD_BEEF);
        total++; if (lo !== 32'hCAFE_0001) begin bad++; $display("FAIL mtlo_busy got=%h exp=%h", lo, 32'hCAFE_0001); end
        wait_idle(n);
        total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL mtlo_busy_commit got=%h exp=%h", {hi, lo}, {32'd2, 32'd14}); end

        // start and MTLO together: start wins.
        hilo_we = 1'b1; hilo_sel = 1'b0;
        drive_start(2'b00, 32'd3, 32'd4);
        hilo_we = 1'b0;
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL start_vs_mtlo got=%h exp=%h", lo, 32'd14); end
        wait_idle(n);
        total++; if ({hi, lo} !== {32'd0, 32'd12}) begin bad++; $display("FAIL start_vs_mtlo_commit got=%h exp=%h", {hi, lo}, {32'd0, 32'd12}); end
    endtask

    task automatic test_cancel();
        int n;
        // hi/lo = 0 / 12 here.
        drive_start(2'b10, 32'd50, 32'd5);
        step(); step(); step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", busy); end
        for (int i = 0; i < 12; i++) step();
        total++; if ({hi, lo} !== {32'd0, 32'd12}) begin bad++; $display("FAIL cancel_keep got=%h exp=%h", {hi, lo}, {32'd0, 32'd12}); end

        // Cancel exactly on the commit edge.
        drive_start(2'b10, 32'd50, 32'd5);
        for (int i = 0; i < 9; i++) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL cancel_commit_pre got=%b exp=1", busy); end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_commit_busy got=%b exp=0", busy); end
        total++; if ({hi, lo} !== {32'd0, 32'd12}) begin bad++; $display("FAIL cancel_commit_keep got=%h exp=%h", {hi, lo}, {32'd0, 32'd12}); end

        // cancel together with start: nothing starts.
        cancel = 1'b1;
        drive_start(2'b00, 32'd9, 32'd9);
        cancel = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_start got=%b exp=0", busy); end
        wait_idle(n);
    endtask

    task automatic test_back_to_back();
        int n;
        drive_start(2'b00, 32'd2, 32'd3);
        // Protocol-error start while busy is ignored.
        drive_start(2'b11, 32'd1, 32'd1);
        wait_idle(n);
        total++; if (n !== 4) begin bad++; $display("FAIL busy_start_cycles got=%0d exp=4", n); end
        total++; if ({hi, lo} !== {32'd0, 32'd6}) begin bad++; $display("FAIL busy_start_result got=%h exp=%h", {hi, lo}, {32'd0, 32'd6}); end
        // Immediately accept the next op in the cycle after commit.
        drive_start(2'b01, 32'h0001_0000, 32'h0001_0000);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        wait_idle(n);
        total++; if ({hi, lo} !== {32'd1, 32'd0}) begin bad++; $display("FAIL b2b_result got=%h exp=%h", {hi, lo}, {32'd1, 32'd0}); end
    endtask

    task automatic test_async_reset();
        int n;
        drive_start(2'b00, 32'd5, 32'd5);
        step();
        #3 rst = 1'b0;
        #1;
        total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL arst_hilo got=%h exp=%h", {hi, lo}, 64'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
        #1 rst = 1'b1;
        step();
        drive_start(2'b00, 32'd7, 32'd6);
        wait_idle(n);
        total++; if (n !== 5) begin bad++; $display("FAIL arst_restart_cycles got=%0d exp=5", n); end
        total++; if ({hi, lo} !== {32'd0, 32'd42}) begin bad++; $display("FAIL arst_restart got=%h exp=%h", {hi, lo}, {32'd0, 32'd42}); end
    endtask

    // ---------------- main ----------------
    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        a        = 32'h0;
        b        = 32'h0;
        hilo_we  = 1'b0;
        hilo_sel = 1'b0;
        cancel   = 1'b0;
        #22;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_hilo();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
